// File: rtl/mux_rr_sel_scheduler.sv
// Round-robin scheduler sharing one 8:1 data mux between 8 requesters.
// Drives a registered one-hot grant and matching mux select. Each grant is
// bounded by a maximum hold time. Between owners the scheduler inserts
// DEAD_CYC idle cycles so the mux output never changes source mid-sample.
module mux_rr_sel_scheduler #(
  parameter int N_REQ    = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int DEAD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             sel_vld,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         hold_q, hold_d;
  logic [3:0]         gap_q, gap_d;

  logic               do_arb;
  logic [SEL_W-1:0]   arb_ptr;
  logic [SEL_W:0]     pick;
  logic               rel;
  logic [7:0]         hold_inc;

  // Returns {found, index} of the first set request at or after p, wrapping
  // modulo N_REQ via the natural overflow of the SEL_W-bit index. Scanning
  // from the farthest offset down lets the nearest candidate win.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [SEL_W-1:0] p);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = p + SEL_W'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // State and datapath registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic: hold/release the current owner, count the dead gap,
  // and arbitrate from the round-robin pointer whenever a new owner may start.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    do_arb   = 1'b0;
    arb_ptr  = ptr_q;
    hold_inc = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
    rel      = !req[sel_q] || ((MAX_HOLD != 0) && (hold_q == 8'(MAX_HOLD)));

    case (state_q)
      S_IDLE: begin
        do_arb = 1'b1;
      end
      S_GRANT: begin
        if (rel) begin
          ptr_d = sel_q + SEL_W'(1);
          gnt_d = '0;
          if (DEAD_CYC > 0) begin
            state_d = S_GAP;
            gap_d   = 4'(DEAD_CYC);
          end else begin
            // Back-to-back handover: arbitrate from the freshly advanced pointer.
            do_arb  = 1'b1;
            arb_ptr = sel_q + SEL_W'(1);
          end
        end else begin
          hold_d = hold_inc;
        end
      end
      S_GAP: begin
        // The last gap cycle already arbitrates, so exactly DEAD_CYC idle cycles appear.
        if (gap_q <= 4'd1) begin
          do_arb = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    pick = rr_pick(req, arb_ptr);

    if (do_arb) begin
      gap_d = '0;
      if (en && pick[SEL_W]) begin
        state_d              = S_GRANT;
        gnt_d                = '0;
        gnt_d[pick[SEL_W-1:0]] = 1'b1;
        sel_d                = pick[SEL_W-1:0];
        hold_d               = 8'd1;
      end else begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    end
  end

  // Output decode: the mux select is valid exactly while a grant is held.
  always_comb begin
    gnt     = gnt_q;
    sel     = sel_q;
    sel_vld = |gnt_q;
    busy    = (state_q != S_IDLE);
  end

endmodule
